// File: rtl/lcompressor_pkg.sv
`default_nettype none
// =====================================================================
// lcompressor_pkg : shared mode encodings and pipeline latency  (rev 1.0)
// =====================================================================
package lcompressor_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_CLIP   = 2'd1;
  localparam logic [1:0] MODE_COMP   = 2'd2;

  localparam int LCOMP_LATENCY = 2;

endpackage
`default_nettype wire

// File: rtl/lcompressor_core.sv
`default_nettype none
// =====================================================================
// lcompressor_core : stateless compare / excess / shift / select  (rev 1.0)
// =====================================================================
module lcompressor_core
  import lcompressor_pkg::*;
#(
  parameter int W_TOTAL = 16,
  parameter int W_SHIFT = 3
) (
  input  logic signed [W_TOTAL-1:0] x,
  input  logic signed [W_TOTAL-1:0] thr_pos,
  input  logic signed [W_TOTAL-1:0] thr_neg,
  input  logic        [1:0]         mode,
  input  logic        [W_SHIFT-1:0] shift,
  output logic        [W_TOTAL-1:0] y,
  output logic                      active
);

  logic signed [W_TOTAL:0]   x_ext, tp_ext, tn_ext, ep, en;
  logic        [W_TOTAL-1:0] y_pos, y_neg;
  logic                      gt, lt, bad_cfg;

  assign x_ext  = {x[W_TOTAL-1], x};
  assign tp_ext = {thr_pos[W_TOTAL-1], thr_pos};
  assign tn_ext = {thr_neg[W_TOTAL-1], thr_neg};

  assign ep      = x_ext - tp_ext;
  assign en      = x_ext - tn_ext;
  assign gt      = x_ext > tp_ext;
  assign lt      = x_ext < tn_ext;
  assign bad_cfg = tp_ext < tn_ext;

  // Result lies between threshold and x, so truncation cannot overflow.
  assign y_pos = W_TOTAL'(tp_ext + (ep >>> shift));
  assign y_neg = W_TOTAL'(tn_ext + (en >>> shift));

  always_comb begin
    y      = x;
    active = 1'b0;
    if (!bad_cfg) begin
      case (mode)
        MODE_CLIP: begin
          if (gt)      y = thr_pos;
          else if (lt) y = thr_neg;
          active = gt | lt;
        end
        MODE_COMP: begin
          if (gt)      y = y_pos;
          else if (lt) y = y_neg;
          active = gt | lt;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcompressor_mc.sv
`default_nettype none
// =====================================================================
// lcompressor_mc : TDM clipper/compressor with per-channel counters  (rev 1.0)
// =====================================================================
module lcompressor_mc
  import lcompressor_pkg::*;
#(
  parameter int W_TOTAL = 16,
  parameter int W_FRAC  = 15,
  parameter int NCH     = 4,
  parameter int W_CH    = 2,
  parameter int W_SHIFT = 3,
  parameter int W_CNT   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic [W_CH-1:0]      i_ch,
  input  logic [W_TOTAL-1:0]   i_data,
  input  logic [W_TOTAL-1:0]   i_threshold_pos,
  input  logic [W_TOTAL-1:0]   i_threshold_neg,
  input  logic [1:0]           i_mode,
  input  logic [W_SHIFT-1:0]   i_ratio_shift,
  input  logic [W_CH-1:0]      i_cnt_sel,
  input  logic                 i_cnt_clr,
  output logic [W_TOTAL-1:0]   o_data,
  output logic [W_CH-1:0]      o_ch,
  output logic                 o_ce,
  output logic                 o_active,
  output logic [W_CNT-1:0]     o_cnt
);

  if (NCH < 1 || W_FRAC >= W_TOTAL) begin : g_cfg_check
    $error("lcompressor_mc: illegal parameter combination");
  end

  logic signed [W_TOTAL-1:0] s1_x, s1_tp, s1_tn;
  logic        [1:0]         s1_mode;
  logic        [W_SHIFT-1:0] s1_shift;
  logic        [W_CH-1:0]    s1_ch;
  logic                      s1_valid;

  logic [W_TOTAL-1:0] core_y;
  logic               core_active;

  logic [W_CNT-1:0] cnt_bank [NCH];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= i_ce;
      if (i_ce) begin
        s1_x     <= i_data;
        s1_tp    <= i_threshold_pos;
        s1_tn    <= i_threshold_neg;
        s1_mode  <= i_mode;
        s1_shift <= i_ratio_shift;
        s1_ch    <= i_ch;
      end
    end
  end

  lcompressor_core #(
    .W_TOTAL (W_TOTAL),
    .W_SHIFT (W_SHIFT)
  ) u_core (
    .x       (s1_x),
    .thr_pos (s1_tp),
    .thr_neg (s1_tn),
    .mode    (s1_mode),
    .shift   (s1_shift),
    .y       (core_y),
    .active  (core_active)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ce     <= 1'b0;
      o_data   <= '0;
      o_ch     <= '0;
      o_active <= 1'b0;
    end else begin
      o_ce <= s1_valid;
      if (s1_valid) begin
        o_data   <= core_y;
        o_ch     <= s1_ch;
        o_active <= core_active;
      end
    end
  end

  // Clear has priority over a same-cycle increment; reads see pre-update values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NCH; i++) cnt_bank[i] <= '0;
      o_cnt <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (i_cnt_clr && int'(i_cnt_sel) == i)
          cnt_bank[i] <= '0;
        else if (o_ce && o_active && int'(o_ch) == i && cnt_bank[i] != '1)
          cnt_bank[i] <= cnt_bank[i] + W_CNT'(1);
      end
      o_cnt <= (int'(i_cnt_sel) < NCH) ? cnt_bank[i_cnt_sel] : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcompressor_mc.sv
`default_nettype none
// =====================================================================
// tb_lcompressor_mc : directed self-checking bench for lcompressor_mc  (rev 1.0)
// =====================================================================
module tb_lcompressor_mc;
  import lcompressor_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [1:0]  ch;
  logic [15:0] din;
  logic [15:0] thr_pos, thr_neg;
  logic [1:0]  mode;
  logic [2:0]  shift;
  logic [1:0]  cnt_sel;
  logic        cnt_clr;

  logic [15:0] dout, dout_s;
  logic [1:0]  ch_out, ch_out_s;
  logic        ce_out, ce_out_s;
  logic        active, active_s;
  logic [15:0] cnt;
  logic [1:0]  cnt_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lcompressor_mc #(.W_CNT(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_ch(ch), .i_data(din),
    .i_threshold_pos(thr_pos), .i_threshold_neg(thr_neg), .i_mode(mode),
    .i_ratio_shift(shift), .i_cnt_sel(cnt_sel), .i_cnt_clr(cnt_clr),
    .o_data(dout), .o_ch(ch_out), .o_ce(ce_out), .o_active(active), .o_cnt(cnt)
  );

  // Narrow-counter instance for saturation
  lcompressor_mc #(.W_CNT(2)) dut_s (
    .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_ch(ch), .i_data(din),
    .i_threshold_pos(thr_pos), .i_threshold_neg(thr_neg), .i_mode(mode),
    .i_ratio_shift(shift), .i_cnt_sel(cnt_sel), .i_cnt_clr(cnt_clr),
    .o_data(dout_s), .o_ch(ch_out_s), .o_ce(ce_out_s), .o_active(active_s), .o_cnt(cnt_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [1:0] c, input logic [15:0] x,
                     input logic [15:0] ey, input logic ea, input string tag);
    ce = 1'b1; ch = c; din = x;
    tick();
    ce = 1'b0;
    tick();
    chk({tag, "_ce"}, 32'(ce_out), 32'd1);
    chk({tag, "_y"},  32'(dout),   32'(ey));
    chk({tag, "_act"}, 32'(active), 32'(ea));
    chk({tag, "_ch"}, 32'(ch_out), 32'(c));
  endtask

  logic [15:0] bx [4];
  logic [15:0] by [4];
  logic        ba [4];

  initial begin
    reset = 1'b1; ce = 1'b1; ch = 2'd0; din = 16'h7FFF;
    thr_pos = 16'h4000; thr_neg = 16'hB000; mode = MODE_BYPASS; shift = 3'd0;
    cnt_sel = 2'd0; cnt_clr = 1'b0;

    // Reset held with a live sample stream
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_ce",  32'(ce_out), 32'd0);
      chk("rst_y",   32'(dout),   32'd0);
      chk("rst_cnt", 32'(cnt),    32'd0);
    end

    reset = 1'b0; ce = 1'b1; din = 16'h1234;
    tick();
    ce = 1'b0;
    chk("lat_early", 32'(ce_out), 32'd0);
    tick();
    chk("lat_ce", 32'(ce_out), 32'd1);
    chk("lat_y",  32'(dout),   32'h1234);

    mode = MODE_CLIP;
    run(2'd0, 16'h5000, 16'h4000, 1'b1, "clip_hi");
    run(2'd0, 16'h8000, 16'hB000, 1'b1, "clip_lo");
    run(2'd0, 16'hFFFF, 16'hFFFF, 1'b0, "clip_in");
    run(2'd0, 16'h4000, 16'h4000, 1'b0, "clip_eq");

    mode = MODE_COMP; shift = 3'd2;
    run(2'd0, 16'h6000, 16'h4800, 1'b1, "comp_hi");
    run(2'd0, 16'h8000, 16'hA400, 1'b1, "comp_lo");
    run(2'd0, 16'h7FFF, 16'h4FFF, 1'b1, "comp_max");
    run(2'd0, 16'h2000, 16'h2000, 1'b0, "comp_in");
    run(2'd0, 16'h8001, 16'hA400, 1'b1, "comp_floor");
    shift = 3'd0;
    run(2'd0, 16'h6000, 16'h6000, 1'b1, "comp_sh0");

    // Back-to-back TDM burst
    mode = MODE_CLIP;
    bx[0] = 16'h5000; by[0] = 16'h4000; ba[0] = 1'b1;
    bx[1] = 16'h1000; by[1] = 16'h1000; ba[1] = 1'b0;
    bx[2] = 16'h0000; by[2] = 16'h0000; ba[2] = 1'b0;
    bx[3] = 16'h8000; by[3] = 16'hB000; ba[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin ce = 1'b1; ch = 2'(k); din = bx[k]; end
      else ce = 1'b0;
      tick();
      if (k >= 1 && k <= 4) begin
        chk("tdm_ce",  32'(ce_out), 32'd1);
        chk("tdm_ch",  32'(ch_out), 32'(k - 1));
        chk("tdm_y",   32'(dout),   32'(by[k-1]));
        chk("tdm_act", 32'(active), 32'(ba[k-1]));
      end else begin
        chk("tdm_idle", 32'(ce_out), 32'd0);
      end
    end
    chk("hold_y", 32'(dout), 32'hB000);

    // Reset in the middle of a burst drops in-flight samples
    ce = 1'b1; ch = 2'd0; din = bx[0];
    tick();
    ch = 2'd1; din = bx[1];
    tick();
    chk("rburst_ce", 32'(ce_out), 32'd1);
    ch = 2'd2; din = bx[2]; reset = 1'b1;
    tick();
    chk("rburst_rst", 32'(ce_out), 32'd0);
    reset = 1'b0; ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rburst_drop", 32'(ce_out), 32'd0);
    end

    // Counters on ch2
    run(2'd2, 16'h5000, 16'h4000, 1'b1, "c2a");
    run(2'd2, 16'h5000, 16'h4000, 1'b1, "c2b");
    run(2'd2, 16'h5000, 16'h4000, 1'b1, "c2c");
    run(2'd2, 16'h1000, 16'h1000, 1'b0, "c2d");
    cnt_sel = 2'd2;
    tick();
    chk("cnt_ch2", 32'(cnt), 32'd3);
    run(2'd2, 16'h5000, 16'h4000, 1'b1, "c2e");
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_preupd", 32'(cnt), 32'd3);
    tick();
    chk("cnt_clr_wins", 32'(cnt), 32'd0);

    // Saturation on ch1
    for (int k = 0; k < 5; k++) run(2'd1, 16'h5000, 16'h4000, 1'b1, "sat");
    cnt_sel = 2'd1;
    tick();
    tick();
    chk("cnt_ch1_wide", 32'(cnt),   32'd5);
    chk("cnt_ch1_sat",  32'(cnt_s), 32'd3);

    // Invalid thresholds and reserved mode
    thr_pos = 16'hB000; thr_neg = 16'h4000;
    run(2'd3, 16'h5000, 16'h5000, 1'b0, "badthr");
    cnt_sel = 2'd3;
    tick();
    tick();
    chk("badthr_cnt", 32'(cnt), 32'd0);
    thr_pos = 16'h4000; thr_neg = 16'hB000; mode = 2'd3;
    run(2'd0, 16'h7000, 16'h7000, 1'b0, "mode3");
    mode = MODE_BYPASS;
    run(2'd0, 16'h7000, 16'h7000, 1'b0, "bypass");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
